servile_sram_arbiter: RTL and testbench

SERVILE_SRAM_ARBITER -- requirements
Module: servile_sram_arbiter

---
 rtl/servile_sram_arbiter.sv | 155 +++++++++++++++
 tb/tb_servile_sram_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/servile_sram_arbiter.sv
// Two-requester 32-bit Wishbone-style front end to a byte-wide SRAM shared with a register file.
// Optional round-robin for simultaneous requests when SERVILE_ARB_RR_EN is defined; m0 wins otherwise.
module servile_sram_arbiter #(
  parameter int aw = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [aw-1:2] i_m0_adr,
  input  logic [31:0]   i_m0_dat,
  input  logic [3:0]    i_m0_sel,
  input  logic          i_m0_we,
  input  logic          i_m0_stb,
  output logic [31:0]   o_m0_rdt,
  output logic          o_m0_ack,
  input  logic [aw-1:2] i_m1_adr,
  input  logic [31:0]   i_m1_dat,
  input  logic [3:0]    i_m1_sel,
  input  logic          i_m1_we,
  input  logic          i_m1_stb,
  output logic [31:0]   o_m1_rdt,
  output logic          o_m1_ack,
  input  logic          i_rf_busy,
  output logic [aw-1:0] o_sram_addr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic          o_sram_ren,
  input  logic [7:0]    i_sram_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT, ACK} state_t;

  state_t          r_state;
  logic            r_gnt;
  logic [1:0]      r_bsel;
  logic            r_rd_pend;
  logic [31:0]     r_rdat;
  logic [31:0]     r_m0_rdt;
  logic [31:0]     r_m1_rdt;
  logic            r_m0_ack;
  logic            r_m1_ack;
  logic [aw-1:2]   r_adr;
  logic [31:0]     r_dat;
  logic [3:0]      r_sel;
  logic            r_we;
`ifdef SERVILE_ARB_RR_EN
  logic            r_last;
`endif

  logic            w_req;
  logic            w_gnt;
  logic            w_issue;
  logic            w_wen;
  logic            w_ren;
  logic [1:0]      w_cap_idx;
  logic [31:0]     w_rdat_nxt;

  assign w_req = i_m0_stb | i_m1_stb;

  // A lone request wins outright; contention goes to m0 unless round-robin is built in.
  always_comb begin
    w_gnt = !i_m0_stb;
`ifdef SERVILE_ARB_RR_EN
    if (i_m0_stb && i_m1_stb) w_gnt = ~r_last;
`endif
  end

  assign w_issue = (r_state == XFER) && !i_rf_busy;
  assign w_wen   = w_issue && r_we && r_sel[r_bsel];
  assign w_ren   = w_issue && !r_we;

  // bsel has already advanced past the byte whose data is arriving now.
  assign w_cap_idx = r_bsel - 2'd1;

  always_comb begin
    w_rdat_nxt = r_rdat;
    if (r_rd_pend) w_rdat_nxt[{w_cap_idx, 3'b000} +: 8] = i_sram_rdata;
  end

  assign o_sram_addr  = {r_adr, r_bsel};
  assign o_sram_wdata = r_dat[{r_bsel, 3'b000} +: 8];
  assign o_sram_wen   = w_wen;
  assign o_sram_ren   = w_ren;
  assign o_m0_ack     = r_m0_ack;
  assign o_m1_ack     = r_m1_ack;
  assign o_m0_rdt     = r_m0_rdt;
  assign o_m1_rdt     = r_m1_rdt;

  always_ff @(posedge i_clk) begin
    if (r_state == IDLE && w_req) begin
      r_adr <= w_gnt ? i_m1_adr : i_m0_adr;
      r_dat <= w_gnt ? i_m1_dat : i_m0_dat;
      r_sel <= w_gnt ? i_m1_sel : i_m0_sel;
      r_we  <= w_gnt ? i_m1_we  : i_m0_we;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= 1'b0;
      r_bsel    <= 2'd0;
      r_rd_pend <= 1'b0;
      r_rdat    <= 32'd0;
      r_m0_rdt  <= 32'd0;
      r_m1_rdt  <= 32'd0;
      r_m0_ack  <= 1'b0;
      r_m1_ack  <= 1'b0;
`ifdef SERVILE_ARB_RR_EN
      r_last    <= 1'b1;
`endif
    end else begin
      r_rd_pend <= w_ren;
      if (r_rd_pend) r_rdat <= w_rdat_nxt;
      r_m0_ack  <= 1'b0;
      r_m1_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_gnt   <= w_gnt;
            r_bsel  <= 2'd0;
            r_state <= XFER;
`ifdef SERVILE_ARB_RR_EN
            r_last  <= w_gnt;
`endif
          end
        end
        XFER: begin
          if (!i_rf_busy) begin
            r_bsel <= r_bsel + 2'd1;
            if (r_bsel == 2'd3) begin
              if (r_we) begin
                r_state  <= ACK;
                r_m0_ack <= !r_gnt;
                r_m1_ack <= r_gnt;
              end else begin
                r_state <= WAIT;
              end
            end
          end
        end
        // Last read byte lands this cycle; publish the full word with the ack.
        WAIT: begin
          r_state  <= ACK;
          r_m0_ack <= !r_gnt;
          r_m1_ack <= r_gnt;
          if (r_gnt) r_m1_rdt <= w_rdat_nxt;
          else       r_m0_rdt <= w_rdat_nxt;
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servile_sram_arbiter.sv
// Randomized bench for servile_sram_arbiter with a transaction-level reference model.
// Honours SERVILE_ARB_RR_EN in the same way as the design build.
module tb_servile_sram_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:2]  i_m0_adr = '0, i_m1_adr = '0;
  logic [31:0] i_m0_dat = '0, i_m1_dat = '0;
  logic [3:0]  i_m0_sel = '0, i_m1_sel = '0;
  logic        i_m0_we = 1'b0, i_m1_we = 1'b0;
  logic        i_m0_stb = 1'b0, i_m1_stb = 1'b0;
  logic [31:0] o_m0_rdt, o_m1_rdt;
  logic        o_m0_ack, o_m1_ack;
  logic        i_rf_busy = 1'b0;
  logic [7:0]  o_sram_addr;
  logic [7:0]  o_sram_wdata;
  logic        o_sram_wen, o_sram_ren;
  logic [7:0]  i_sram_rdata;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rdt [2];
  int          last_gnt;
  bit          init_done = 1'b0;

  servile_sram_arbiter #(.aw(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat), .i_m0_sel(i_m0_sel), .i_m0_we(i_m0_we), .i_m0_stb(i_m0_stb),
    .o_m0_rdt(o_m0_rdt), .o_m0_ack(o_m0_ack),
    .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat), .i_m1_sel(i_m1_sel), .i_m1_we(i_m1_we), .i_m1_stb(i_m1_stb),
    .o_m1_rdt(o_m1_rdt), .o_m1_ack(o_m1_ack),
    .i_rf_busy(i_rf_busy),
    .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata),
    .o_sram_wen(o_sram_wen), .o_sram_ren(o_sram_ren),
    .i_sram_rdata(i_sram_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Byte SRAM with one-cycle read latency, preloaded with a known pattern.
  always @(posedge i_clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 11);
      i_sram_rdata <= 8'h00;
    end else begin
      if (o_sram_wen) mem[o_sram_addr] <= o_sram_wdata;
      if (o_sram_ren) i_sram_rdata <= mem[o_sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [5:0] a);
    return {ref_mem[{a, 2'd3}], ref_mem[{a, 2'd2}], ref_mem[{a, 2'd1}], ref_mem[{a, 2'd0}]};
  endfunction

  task automatic run_txn(input bit s0, input bit s1,
                         input logic [5:0] a0, input logic [31:0] d0, input logic [3:0] e0, input bit w0,
                         input logic [5:0] a1, input logic [31:0] d1, input logic [3:0] e1, input bit w1,
                         input logic [15:0] bz);
    int win, k, n, lat, obs_lat, obs_win, mism;
    logic [5:0] a;
    logic [31:0] d;
    logic [3:0] e;
    bit we, ex_issue, ex_wen, ex_ren;
    if (s0 && s1) begin
`ifdef SERVILE_ARB_RR_EN
      win = (last_gnt == 1) ? 0 : 1;
`else
      win = 0;
`endif
    end else begin
      win = s0 ? 0 : 1;
    end
    last_gnt = win;
    a  = win ? a1 : a0;
    d  = win ? d1 : d0;
    e  = win ? e1 : e0;
    we = win ? w1 : w0;
    // Four non-stalled slots after the grant cycle, then ack (reads add a capture cycle).
    n = 0; k = 0;
    while (n < 4) begin
      k++;
      if (!(k < 16 && bz[k])) n++;
    end
    lat = k + (we ? 1 : 2);

    @(posedge i_clk); #1;
    i_m0_stb = s0; i_m0_adr = a0; i_m0_dat = d0; i_m0_sel = e0; i_m0_we = w0;
    i_m1_stb = s1; i_m1_adr = a1; i_m1_dat = d1; i_m1_sel = e1; i_m1_we = w1;
    i_rf_busy = bz[0];
    n = 0; mism = 0; obs_lat = 0; obs_win = -1;
    for (int c = 1; c <= 40 && obs_lat == 0; c++) begin
      @(posedge i_clk); #1;
      i_m0_stb = 1'b0; i_m1_stb = 1'b0;
      i_m0_dat = $urandom; i_m1_dat = $urandom;
      i_rf_busy = (c < 16) ? bz[c] : 1'b0;
      @(negedge i_clk);
      ex_issue = (n < 4) && !i_rf_busy;
      ex_wen   = ex_issue && we && e[n];
      ex_ren   = ex_issue && !we;
      if (o_sram_wen !== ex_wen || o_sram_ren !== ex_ren) mism++;
      if (ex_issue && o_sram_addr !== {a, 2'(n)}) mism++;
      if (ex_wen && o_sram_wdata !== d[8*n +: 8]) mism++;
      if (ex_issue) n++;
      if (o_m0_ack && o_m1_ack) mism++;
      if (o_m0_ack) begin obs_lat = c; obs_win = 0; end
      if (o_m1_ack) begin obs_lat = c; obs_win = 1; end
    end
    chk("latency", 32'(obs_lat), 32'(lat));
    chk("grant", 32'(obs_win), 32'(win));
    chk("sram_port", 32'(mism), 32'd0);
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (e[b]) ref_mem[{a, 2'(b)}] = d[8*b +: 8];
    end else begin
      exp_rdt[win] = ref_word(a);
    end
    chk("rdt_m0", o_m0_rdt, exp_rdt[0]);
    chk("rdt_m1", o_m1_rdt, exp_rdt[1]);
    @(posedge i_clk); #1;
    i_rf_busy = 1'b0;
    @(negedge i_clk);
    chk("ack_one_cycle", {30'd0, o_m1_ack, o_m0_ack}, 32'd0);
  endtask

  initial begin
    int acks;
    bit s0, s1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    exp_rdt[0] = 32'd0; exp_rdt[1] = 32'd0;
    last_gnt = 1;
    @(posedge i_clk); #1;
    init_done = 1'b1;
    @(negedge i_clk);
    chk("rst_ack", {30'd0, o_m1_ack, o_m0_ack}, 32'd0);
    chk("rst_wen_ren", {30'd0, o_sram_wen, o_sram_ren}, 32'd0);
    chk("rst_rdt0", o_m0_rdt, 32'd0);
    chk("rst_rdt1", o_m1_rdt, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Word write, readback by the other requester, partial write, stalled read.
    run_txn(1, 0, 6'h05, 32'hA1B2C3D4, 4'hF, 1, 6'h00, 32'h0, 4'h0, 0, 16'h0000);
    chk("mem14_17", {mem[8'h17], mem[8'h16], mem[8'h15], mem[8'h14]}, 32'hA1B2C3D4);
    run_txn(0, 1, 6'h00, 32'h0, 4'h0, 0, 6'h05, 32'h0, 4'h0, 0, 16'h0000);
    chk("m1_read_word", o_m1_rdt, 32'hA1B2C3D4);
    run_txn(1, 0, 6'h06, 32'h55667788, 4'h5, 1, 6'h00, 32'h0, 4'h0, 0, 16'h0000);
    run_txn(1, 0, 6'h05, 32'h0, 4'h0, 0, 6'h00, 32'h0, 4'h0, 0, 16'h000C);
    chk("stalled_read_word", o_m0_rdt, 32'hA1B2C3D4);

    // Three back-to-back contended requests.
    for (int i = 0; i < 3; i++)
      run_txn(1, 1, 6'h06, 32'h0, 4'h0, 0, 6'h05, 32'h0, 4'h0, 0, 16'h0000);

    // Reset in the middle of a read.
    @(posedge i_clk); #1;
    i_m1_stb = 1'b1; i_m1_adr = 6'h05; i_m1_we = 1'b0; i_rf_busy = 1'b0;
    @(posedge i_clk); #1;
    i_m1_stb = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_wen_ren", {30'd0, o_sram_wen, o_sram_ren}, 32'd0);
    chk("midrst_ack", {30'd0, o_m1_ack, o_m0_ack}, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    last_gnt = 1;
    exp_rdt[0] = 32'd0; exp_rdt[1] = 32'd0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_m0_ack || o_m1_ack || o_sram_wen || o_sram_ren) acks++;
    end
    chk("midrst_quiet", 32'(acks), 32'd0);
    run_txn(1, 1, 6'h05, 32'h0, 4'h0, 0, 6'h06, 32'h0, 4'h0, 0, 16'h0000);

    // Randomized mix of requesters, directions, byte selects and stalls.
    for (int t = 0; t < 40; t++) begin
      s0 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      if (!s0 && !s1) s0 = 1'b1;
      run_txn(s0, s1,
              6'($urandom_range(0, 7)), $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
              6'($urandom_range(0, 7)), $urandom, 4'($urandom), 1'($urandom_range(0, 1)),
              16'($urandom & $urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
